// File: rtl/reg_loader.sv
// Operator-driven writer for an 8x32 register file: debounced keys build a word from switch nibbles and commit it.
// Latency: a debounced commit event in cycle N drives wr_en high in cycle N+1 only, as a single-cycle pulse.
// Backpressure: there is none to downstream; key events that arrive while busy is high are dropped, not queued.
//
// Ports:
//   CLOCK_50, resetn              clock (rising edge) and asynchronous active-low reset
//   nibble_in, addr_in            switch nibble to shift in, and target register for a commit
//   shift/commit/clear_key_n      active-low board keys (synchronised and debounced here)
//   wr_en, wr_addr, wr_data       register_file write port; addr/data hold the last commit
//   shadow_word, nib_count        word under construction and the number of nibbles entered
//   busy, reject                  busy during the write (and verify); reject pulses on a commit to R0
// Optional macro READBACK_VERIFY_EN adds rd_addr/rd_data/verify_err and a VERIFY state after WRITE.
module reg_loader #(
    parameter int DATA_W          = 32,
    parameter int ADDR_W          = 3,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic              CLOCK_50,
    input  logic              resetn,
    input  logic [3:0]        nibble_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic              shift_key_n,
    input  logic              commit_key_n,
    input  logic              clear_key_n,
`ifdef READBACK_VERIFY_EN
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              verify_err,
`endif
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] shadow_word,
    output logic [3:0]        nib_count,
    output logic              busy,
    output logic              reject
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0]      NIB_MAX  = 4'(DATA_W / 4);

    // Key index order: 0 = shift, 1 = commit, 2 = clear.
    localparam int K_SHIFT  = 0;
    localparam int K_COMMIT = 1;
    localparam int K_CLEAR  = 2;

    logic [2:0]       key_raw_n;
    logic [2:0]       sync1;
    logic [2:0]       sync2;
    logic [2:0]       level;   // accepted debounced level, 1 = released
    logic [2:0]       evt;     // one-cycle press events
    logic [CNT_W-1:0] cnt [3];

    assign key_raw_n = {clear_key_n, commit_key_n, shift_key_n};

    // The counter runs only while the synchronised sample disagrees with the
    // accepted level; any agreeing sample restarts it, so short bounces are
    // ignored. A press event fires only on an accepted released->pressed change.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            sync1 <= '1;
            sync2 <= '1;
            level <= '1;
            evt   <= '0;
            for (int i = 0; i < 3; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= key_raw_n;
            sync2 <= sync1;
            for (int i = 0; i < 3; i++) begin
                evt[i] <= 1'b0;
                if (sync2[i] == level[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    cnt[i]   <= '0;
                    level[i] <= sync2[i];
                    evt[i]   <= ~sync2[i];
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        VERIFY = 2'd2
    } state_t;

    state_t state;

`ifdef READBACK_VERIFY_EN
    // The register file read port is combinational, so pointing it at the
    // write address lets VERIFY compare the stored value one cycle later.
    assign rd_addr = wr_addr;
`endif

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            shadow_word <= '0;
            nib_count   <= '0;
            busy        <= 1'b0;
            reject      <= 1'b0;
`ifdef READBACK_VERIFY_EN
            verify_err  <= 1'b0;
`endif
        end else begin
            reject <= 1'b0;
            case (state)
                IDLE: begin
                    // Priority clear > commit > shift; lower events in the same cycle are dropped.
                    if (evt[K_CLEAR]) begin
                        shadow_word <= '0;
                        nib_count   <= '0;
                    end else if (evt[K_COMMIT]) begin
                        if (addr_in != '0) begin
                            wr_addr    <= addr_in;
                            wr_data    <= shadow_word;
                            wr_en      <= 1'b1;
                            busy       <= 1'b1;
                            state      <= WRITE;
`ifdef READBACK_VERIFY_EN
                            verify_err <= 1'b0;
`endif
                        end else begin
                            reject <= 1'b1;
                        end
                    end else if (evt[K_SHIFT]) begin
                        shadow_word <= {shadow_word[DATA_W-5:0], nibble_in};
                        if (nib_count != NIB_MAX) begin
                            nib_count <= nib_count + 4'd1;
                        end
                    end
                end
                WRITE: begin
                    wr_en       <= 1'b0;
                    shadow_word <= '0;
                    nib_count   <= '0;
`ifdef READBACK_VERIFY_EN
                    state       <= VERIFY;
`else
                    busy        <= 1'b0;
                    state       <= IDLE;
`endif
                end
`ifdef READBACK_VERIFY_EN
                VERIFY: begin
                    verify_err <= verify_err | (rd_data != wr_data);
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
`endif
                default: begin
                    wr_en <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_loader.sv
// Randomised and directed bench for reg_loader with a queue-based scoreboard.
// Latency: not applicable; the bench checks write and reject pulses as the DUT presents them.
// Backpressure: not applicable; each key press is held long enough to pass the debouncer.
module tb_reg_loader;

    localparam int DW = 32;
    localparam int AW = 3;
    localparam int DB = 4;

    logic          CLOCK_50 = 1'b0;
    logic          resetn;
    logic [3:0]    nibble_in;
    logic [AW-1:0] addr_in;
    logic          shift_key_n;
    logic          commit_key_n;
    logic          clear_key_n;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] shadow_word;
    logic [3:0]    nib_count;
    logic          busy;
    logic          reject;
`ifdef READBACK_VERIFY_EN
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          verify_err;
    assign rd_data = wr_data ^ 32'h1;   // deliberately faulty register file
`endif

    always #5 CLOCK_50 = ~CLOCK_50;

    reg_loader #(.DATA_W(DW), .ADDR_W(AW), .DEBOUNCE_CYCLES(DB)) dut (
        .CLOCK_50    (CLOCK_50),
        .resetn      (resetn),
        .nibble_in   (nibble_in),
        .addr_in     (addr_in),
        .shift_key_n (shift_key_n),
        .commit_key_n(commit_key_n),
        .clear_key_n (clear_key_n),
`ifdef READBACK_VERIFY_EN
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .verify_err  (verify_err),
`endif
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .shadow_word (shadow_word),
        .nib_count   (nib_count),
        .busy        (busy),
        .reject      (reject)
    );

    int checks = 0;
    int errs   = 0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // Scoreboard of expected output pulses.
    typedef struct {
        bit            is_rej;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } exp_t;
    exp_t q[$];

    // Reference model of the operator-visible state.
    logic [DW-1:0] m_shadow;
    int            m_cnt;
    bit            m_last_vld;
    logic [AW-1:0] m_last_a;
    logic [DW-1:0] m_last_d;

    // Monitor: pops an expectation whenever a write or reject pulse appears.
    exp_t e;
    bit   prev_pulse = 1'b0;
    always @(negedge CLOCK_50) begin
        if (resetn) begin
            if (wr_en || reject) begin
                if (q.size() == 0) begin
                    chk("unexpected_pulse", {62'd0, wr_en, reject}, 64'd0);
                end else begin
                    e = q.pop_front();
                    if (e.is_rej) begin
                        chk("reject", reject, 1);
                        chk("reject_no_wr", wr_en, 0);
                    end else begin
                        chk("wr_en", wr_en, 1);
                        chk("wr_addr", wr_addr, e.a);
                        chk("wr_data", wr_data, e.d);
                        chk("busy_in_write", busy, 1);
                        chk("no_reject_in_write", reject, 0);
                    end
                end
                chk("pulse_one_cycle", prev_pulse, 0);
            end
            prev_pulse = wr_en | reject;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic model_reset();
        m_shadow   = '0;
        m_cnt      = 0;
        m_last_vld = 1'b0;
    endtask

    // keys = {clear, commit, shift}; updates the model then presses the keys together.
    task automatic op(input logic [2:0] keys, input logic [3:0] nib, input logic [AW-1:0] a);
        exp_t x;
        nibble_in = nib;
        addr_in   = a;
        if (keys[2]) begin
            m_shadow = '0;
            m_cnt    = 0;
        end else if (keys[1]) begin
            if (a != 0) begin
                x.is_rej = 1'b0; x.a = a; x.d = m_shadow;
                q.push_back(x);
                m_last_vld = 1'b1; m_last_a = a; m_last_d = m_shadow;
                m_shadow = '0;
                m_cnt    = 0;
            end else begin
                x.is_rej = 1'b1; x.a = '0; x.d = '0;
                q.push_back(x);
            end
        end else if (keys[0]) begin
            m_shadow = (m_shadow << 4) | DW'(nib);
            m_cnt    = (m_cnt < DW / 4) ? m_cnt + 1 : DW / 4;
        end
        clear_key_n  = ~keys[2];
        commit_key_n = ~keys[1];
        shift_key_n  = ~keys[0];
        cyc(DB + 8);
        clear_key_n  = 1'b1;
        commit_key_n = 1'b1;
        shift_key_n  = 1'b1;
        cyc(DB + 8);
        chk("shadow_word", shadow_word, m_shadow);
        chk("nib_count", nib_count, 64'(m_cnt));
        if (m_last_vld) begin
            chk("wr_addr_hold", wr_addr, m_last_a);
            chk("wr_data_hold", wr_data, m_last_d);
        end
    endtask

    initial begin
        int waited;
        bit seen;
        int r;

        resetn       = 1'b0;
        nibble_in    = '0;
        addr_in      = '0;
        shift_key_n  = 1'b1;
        commit_key_n = 1'b1;
        clear_key_n  = 1'b1;
        model_reset();
        cyc(3);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_shadow", shadow_word, 0);
        chk("rst_nib_count", nib_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_reject", reject, 0);
        resetn = 1'b1;
        cyc(3);

        // Eight shifts then commit to R3.
        for (int i = 1; i <= 8; i++) op(3'b001, 4'(i), '0);
        chk("eight_shifts", shadow_word, 32'h12345678);
        op(3'b010, 4'h0, 3'd3);
        chk("after_commit_shadow", shadow_word, 0);
`ifdef READBACK_VERIFY_EN
        chk("verify_err", verify_err, 1);
`endif

        // Nine shifts saturate the count and drop the oldest nibble.
        for (int i = 1; i <= 9; i++) op(3'b001, 4'(i), '0);
        chk("nine_shifts", shadow_word, 32'h23456789);
        chk("nine_shifts_cnt", nib_count, 8);
        op(3'b100, 4'h0, '0);

        // Commit to R0 is rejected and keeps the shadow.
        op(3'b001, 4'hA, '0);
        op(3'b001, 4'hB, '0);
        op(3'b010, 4'h0, 3'd0);
        chk("reject_keeps_shadow", shadow_word, 32'hAB);

        // Short bounce then a long hold: exactly one shift.
        nibble_in   = 4'h5;
        shift_key_n = 1'b0; cyc(2);
        shift_key_n = 1'b1; cyc(3);
        shift_key_n = 1'b0; cyc(20);
        shift_key_n = 1'b1; cyc(DB + 8);
        m_shadow = 32'hAB5; m_cnt = 3;
        chk("bounce_shadow", shadow_word, 32'hAB5);
        chk("bounce_cnt", nib_count, 3);

        // Clear beats commit; commit beats shift.
        op(3'b110, 4'h0, 3'd2);
        chk("clear_beats_commit", shadow_word, 0);
        op(3'b001, 4'h1, '0);
        op(3'b001, 4'h2, '0);
        op(3'b011, 4'h9, 3'd5);

        // Commit with nothing entered writes zero.
        op(3'b010, 4'h0, 3'd6);

        // Reset asserted during the WRITE cycle.
        op(3'b001, 4'hC, '0);
        begin
            exp_t x;
            x.is_rej = 1'b0; x.a = 3'd7; x.d = m_shadow;
            q.push_back(x);
        end
        addr_in      = 3'd7;
        commit_key_n = 1'b0;
        seen   = 1'b0;
        waited = 0;
        while (!seen && waited < 40) begin
            cyc(1);
            waited++;
            if (wr_en) seen = 1'b1;
        end
        chk("write_seen_before_reset", seen, 1);
        chk("write_data_before_reset", wr_data, 32'hC);
        resetn = 1'b0;
        #1;
        chk("arst_wr_en", wr_en, 0);
        chk("arst_wr_addr", wr_addr, 0);
        chk("arst_wr_data", wr_data, 0);
        chk("arst_shadow", shadow_word, 0);
        chk("arst_busy", busy, 0);
        commit_key_n = 1'b1;
        q.delete();
        model_reset();
        cyc(4);
        resetn = 1'b1;
        cyc(4);

        // Randomised operation mix.
        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 11);
            if (r <= 5)       op(3'b001, 4'($urandom_range(0, 15)), '0);
            else if (r == 6)  op(3'b100, 4'h0, '0);
            else if (r <= 9)  op(3'b010, 4'h0, AW'($urandom_range(0, 7)));
            else              op(3'($urandom_range(1, 7)), 4'($urandom_range(0, 15)),
                                 AW'($urandom_range(0, 7)));
        end

        cyc(10);
        chk("scoreboard_drained", 64'(q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
        $finish;
    end

endmodule
